lightsaber_telemetry_tx: RTL

//  Reads the live lightsaber register outputs (on/off, color, length, blade config, power)
//  and transmits them as an 8-byte telemetry frame over a valid/ready byte stream.

---
 rtl/lightsaber_telemetry_tx_if.sv | 18 +
 rtl/lightsaber_telemetry_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lightsaber_telemetry_tx_if.sv
// Byte-stream link carrying telemetry frames from the transmitter to its sink.
interface lightsaber_telemetry_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/lightsaber_telemetry_tx.sv
// Lightsaber telemetry transmitter: snapshots the live settings and sends an
// 8-byte frame (header, status, R, G, B, length decimal, power, checksum)
// over a valid/ready byte stream, on request or from a periodic timer.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no frame in flight; a trigger or pending flag starts one
// ST_SEND | presenting byte idx_q, advancing on each accept
module lightsaber_telemetry_tx #(
   parameter int unsigned PERIOD = 100,
   parameter logic [7:0]  HEADER = 8'hA5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_i,
   input  logic                      on_i,
   input  logic [7:0]                r_i,
   input  logic [7:0]                g_i,
   input  logic [7:0]                b_i,
   input  logic [1:0]                cfg_i,
   input  logic [1:0]                len_int_i,
   input  logic [5:0]                len_dec_i,
   input  logic [7:0]                power_i,
   input  logic                      power_warn_i,
   lightsaber_telemetry_tx_if.master tx,
   output logic                      busy_o,
   output logic                      frame_done_o,
   output logic [7:0]                overrun_cnt_o
);

   localparam int unsigned     TW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TW-1:0]   TMR_LOAD = TW'(PERIOD - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic            pend_q, pend_d;
   logic [7:0]      ovr_q, ovr_d;
   logic            done_q, done_d;
   logic [5:0][7:0] snap_q, snap_d;
   logic [TW-1:0]   tmr_q, tmr_d;

   logic            expire;
   logic            trig;
   logic [7:0]      status;
   logic [7:0]      csum;
   logic [7:0]      byte_sel;

   // Free-running down-counter; terminal count at zero marks a timer expiry.
   always_comb begin
      tmr_d = (tmr_q == '0) ? TMR_LOAD : tmr_q - TW'(1);
   end

   // Timer register, runs independently of frame activity.
   always_ff @(posedge clk) begin
      if (rst) tmr_q <= TMR_LOAD;
      else     tmr_q <= tmr_d;
   end

   // A request and a coincident expiry collapse into a single trigger.
   assign expire = (PERIOD != 0) && (tmr_q == '0);
   assign trig   = req_i | expire;
   assign status = {on_i, power_warn_i, cfg_i, len_int_i, 2'b00};

   // Next-state logic: frame start, byte advance, pending and overrun tracking.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;
      done_d  = 1'b0;
      snap_d  = snap_q;
      case (state_q)
         ST_IDLE: begin
            if (trig || pend_q) begin
               state_d = ST_SEND;
               idx_d   = 3'd0;
               // a fresh trigger landing on the pending-start cycle stays queued
               pend_d  = pend_q & trig;
               snap_d  = {power_i, {2'b00, len_dec_i}, b_i, g_i, r_i, status};
            end
         end
         ST_SEND: begin
            if (trig) begin
               if (!pend_q)             pend_d = 1'b1;
               else if (ovr_q != 8'hFF) ovr_d  = ovr_q + 8'd1;
            end
            if (tx.tx_ready) begin
               if (idx_q == 3'd7) begin
                  state_d = ST_IDLE;
                  idx_d   = 3'd0;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + 3'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         pend_q  <= 1'b0;
         ovr_q   <= 8'd0;
         done_q  <= 1'b0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         done_q  <= done_d;
         snap_q  <= snap_d;
      end
   end

   // Checksum is over the snapshot, so live input changes cannot disturb it.
   always_comb begin
      csum = HEADER + snap_q[0] + snap_q[1] + snap_q[2]
           + snap_q[3] + snap_q[4] + snap_q[5];
   end

   // Select the byte at the current frame index.
   always_comb begin
      byte_sel = 8'h00;
      case (idx_q)
         3'd0:    byte_sel = HEADER;
         3'd1:    byte_sel = snap_q[0];
         3'd2:    byte_sel = snap_q[1];
         3'd3:    byte_sel = snap_q[2];
         3'd4:    byte_sel = snap_q[3];
         3'd5:    byte_sel = snap_q[4];
         3'd6:    byte_sel = snap_q[5];
         default: byte_sel = csum;
      endcase
   end

   assign tx.tx_valid   = (state_q == ST_SEND);
   assign tx.tx_data    = (state_q == ST_SEND) ? byte_sel : 8'h00;
   assign busy_o        = (state_q == ST_SEND);
   assign frame_done_o  = done_q;
   assign overrun_cnt_o = ovr_q;

endmodule
